scfifo_rd_stream: RTL

Read-side adapter for `scfifo_ver` in normal mode (`lpm_showahead = "OFF"`). It drives the FIFO's `rdreq`, absorbs the one-cycle `q` latency in a small register buffer, and presents the data as a valid/ready stream with full throughput. It sits directly on the FIFO's read port and feeds downstream stream consumers.

---
 rtl/scfifo_rd_stream_pkg.sv | 14 +
 rtl/scfifo_rd_buf.sv | 52 +++++
 rtl/scfifo_rd_stream.sv | 54 +++++
 3 files changed

// File: rtl/scfifo_rd_stream_pkg.sv
// scfifo_rd_stream_pkg: width helpers shared by the read-stream adapter and its buffer ring
package scfifo_rd_stream_pkg;

    // Pointer width for a ring of depth entries, never narrower than one bit.
    function automatic int ptr_bits(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

    // Occupancy width able to hold the values 0..depth.
    function automatic int cnt_bits(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/scfifo_rd_buf.sv
// scfifo_rd_buf: bufdepth-entry register ring that absorbs the words returned by the FIFO.
//   clock, aclr (async, active-high), sclr (sync clear of pointers and count)
//   push/push_dat : store push_dat at the write pointer
//   pop           : advance the read pointer (caller guarantees count != 0)
//   head          : data register at the read pointer
//   count         : current occupancy
module scfifo_rd_buf
    import scfifo_rd_stream_pkg::*;
#(
    parameter int width    = 8,
    parameter int bufdepth = 3
) (
    input  logic                            clock,
    input  logic                            aclr,
    input  logic                            sclr,
    input  logic                            push,
    input  logic [width-1:0]                push_dat,
    input  logic                            pop,
    output logic [width-1:0]                head,
    output logic [cnt_bits(bufdepth)-1:0]   count
);
    localparam int ptrw = ptr_bits(bufdepth);
    localparam int cntw = cnt_bits(bufdepth);
    localparam logic [ptrw-1:0] last = ptrw'(bufdepth - 1);

    logic [ptrw-1:0]  wptr, rptr;
    logic [width-1:0] mem [bufdepth];

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < bufdepth; i++) mem[i] <= '0;
        end else if (sclr) begin
            // data registers keep their contents; only the bookkeeping is cleared
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= push_dat;
                wptr      <= (wptr == last) ? '0 : wptr + ptrw'(1);
            end
            if (pop) rptr <= (rptr == last) ? '0 : rptr + ptrw'(1);
            count <= count + cntw'(push) - cntw'(pop);
        end
    end

    assign head = mem[rptr];

endmodule

// File: rtl/scfifo_rd_stream.sv
// scfifo_rd_stream: turns the read port of a normal-mode scfifo into a valid/ready stream.
//   clock, aclr (async, active-high), sclr (sync clear)
//   fifo_rdreq/fifo_q/fifo_empty : FIFO read port, q valid the cycle after rdreq
//   src_dat/src_val/src_rdy      : output stream
//   bufused                      : words currently held in the output buffer
module scfifo_rd_stream
    import scfifo_rd_stream_pkg::*;
#(
    parameter int width    = 8,
    parameter int bufdepth = 3
) (
    input  logic                            clock,
    input  logic                            aclr,
    input  logic                            sclr,
    output logic                            fifo_rdreq,
    input  logic [width-1:0]                fifo_q,
    input  logic                            fifo_empty,
    output logic [width-1:0]                src_dat,
    output logic                            src_val,
    input  logic                            src_rdy,
    output logic [cnt_bits(bufdepth)-1:0]   bufused
);
    localparam int cntw = cnt_bits(bufdepth);

    logic            inflight;
    logic [cntw-1:0] cnt;
    logic [cntw:0]   pending;

    // Reserve a slot for every word already requested so the ring can never overflow;
    // src_rdy is deliberately not part of this decision.
    assign pending    = {1'b0, cnt} + {{cntw{1'b0}}, inflight};
    assign fifo_rdreq = ~aclr & ~sclr & ~fifo_empty & (pending < (cntw + 1)'(bufdepth));

    // rdreq is already forced low during sclr, so inflight clears on that edge too
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) inflight <= 1'b0;
        else      inflight <= fifo_rdreq;
    end

    assign src_val = (cnt != '0);
    assign bufused = cnt;

    scfifo_rd_buf #(.width(width), .bufdepth(bufdepth)) u_buf (
        .clock    (clock),
        .aclr     (aclr),
        .sclr     (sclr),
        .push     (inflight),
        .push_dat (fifo_q),
        .pop      (src_val & src_rdy),
        .head     (src_dat),
        .count    (cnt)
    );

endmodule
